// File: rtl/alu_defs_pkg.sv
// Shared definitions for the ALU self-test slice.
// Contents: ALU opcode codes, bus widths, driver FSM state type, and the LFSR step function.
package alu_defs;

  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned DATA_W   = 32;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_NOR = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_SRA = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'd9;
  localparam logic [ALU_OP_W-1:0] ALU_LUI = 4'd10;

  // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
  localparam logic [DATA_W-1:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {StIdle, StDrive, StWait, StCheck, StDone} drv_state_e;

  function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/alu_selftest_driver_if.sv
// ALU operand/result bus between the self-test driver (master) and the ALU (slave).
//   alu_op/alu_a/alu_b : opcode and operands, driven by master
//   alu_c/alu_over     : result and overflow flag, driven by slave
interface alu_selftest_driver_if;
  import alu_defs::*;

  logic [ALU_OP_W-1:0] alu_op;
  logic [DATA_W-1:0]   alu_a;
  logic [DATA_W-1:0]   alu_b;
  logic [DATA_W-1:0]   alu_c;
  logic                alu_over;

  modport master (output alu_op, alu_a, alu_b, input alu_c, alu_over);
  modport slave  (input alu_op, alu_a, alu_b, output alu_c, alu_over);
endinterface

// File: rtl/alu_golden_model.sv
// Combinational reference ALU: op/a/b -> expected c/over.
//   op   in  4   ALU opcode (11..15 reserved, c = 0)
//   a, b in  32  operands
//   c    out 32  expected result
//   over out 1   expected signed overflow (ADD/SUB only)
module alu_golden_model
  import alu_defs::*;
(
  input  logic [ALU_OP_W-1:0] op,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic [DATA_W-1:0]   c,
  output logic                over
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    c    = '0;
    over = 1'b0;
    case (op)
      ALU_ADD: begin
        c    = sum;
        over = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUB: begin
        c    = diff;
        over = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_AND: c = a & b;
      ALU_OR:  c = a | b;
      ALU_XOR: c = a ^ b;
      ALU_NOR: c = ~(a | b);
      ALU_SLL: c = a << b[4:0];
      ALU_SRL: c = a >> b[4:0];
      ALU_SRA: c = DATA_W'($signed(a) >>> b[4:0]);
      ALU_SLT: c = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_LUI: c = {b[15:0], 16'h0000};
      default: c = '0;
    endcase
  end

endmodule

// File: rtl/alu_selftest_driver.sv
// Built-in self-test master for the execute-stage ALU.
// Walks opcodes 0..NUM_OPS-1, VECS_PER_OP vectors each (4 corners then LFSR vectors), drives
// them on the ALU bus, checks the returned result against alu_golden_model and records the
// first mismatch.
//   clk, reset : clock, asynchronous active-high reset
//   start      : one-cycle run request, honoured only when idle or in the done cycle
//   alu        : ALU bus (master side)
//   busy       : run in progress
//   done       : one-cycle completion pulse
//   pass       : no mismatches in the last run
//   err_count  : saturating mismatch count
//   err_op/a/b : opcode and operands of the first mismatch
module alu_selftest_driver
  import alu_defs::*;
#(
  parameter int unsigned       NUM_OPS     = 11,
  parameter int unsigned       VECS_PER_OP = 16,
  parameter int unsigned       ALU_LATENCY = 0,
  parameter logic [DATA_W-1:0] SEED        = 32'hACE1_2014
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  alu_selftest_driver_if.master alu,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          err_count,
  output logic [ALU_OP_W-1:0]  err_op,
  output logic [DATA_W-1:0]    err_a,
  output logic [DATA_W-1:0]    err_b
);

  localparam int unsigned VecW = (VECS_PER_OP > 1) ? $clog2(VECS_PER_OP) : 1;
  localparam int unsigned LatW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam logic [VecW-1:0]     LastVec = VecW'(VECS_PER_OP - 1);
  localparam logic [ALU_OP_W-1:0] LastOp  = ALU_OP_W'(NUM_OPS - 1);
  localparam logic [LatW-1:0]     LastLat = LatW'((ALU_LATENCY > 0) ? ALU_LATENCY - 1 : 0);

  drv_state_e          state_q, state_d;
  logic [ALU_OP_W-1:0] op_q;
  logic [VecW-1:0]     vec_q;
  logic [LatW-1:0]     lat_q;
  logic [DATA_W-1:0]   lfsr_q;
  logic [ALU_OP_W-1:0] drv_op_q;
  logic [DATA_W-1:0]   drv_a_q, drv_b_q;
  logic [15:0]         err_count_q;
  logic [ALU_OP_W-1:0] err_op_q;
  logic [DATA_W-1:0]   err_a_q, err_b_q;
  logic                pass_q;

  logic              accept, last_vec, last_op, random_vec, mismatch, exp_over;
  logic [DATA_W-1:0] vec_a, vec_b, exp_c;

  assign accept     = start && ((state_q == StIdle) || (state_q == StDone));
  assign last_vec   = (vec_q == LastVec);
  assign last_op    = (op_q == LastOp);
  assign random_vec = (vec_q > VecW'(3));

  // Corner vectors first, LFSR-derived vectors afterwards.
  always_comb begin
    vec_a = lfsr_q;
    vec_b = {lfsr_q[15:0], lfsr_q[31:16]} ^ 32'h5A5A_5A5A;
    case (vec_q)
      VecW'(0): begin vec_a = 32'h7FFF_FFFF; vec_b = 32'h0000_0001; end
      VecW'(1): begin vec_a = 32'h8000_0000; vec_b = 32'h0000_0001; end
      VecW'(2): begin vec_a = 32'hFFFF_FFFF; vec_b = 32'hFFFF_FFFF; end
      VecW'(3): begin vec_a = 32'h0000_0000; vec_b = 32'h0000_001F; end
      default: ;
    endcase
  end

  alu_golden_model u_golden (
    .op   (drv_op_q),
    .a    (drv_a_q),
    .b    (drv_b_q),
    .c    (exp_c),
    .over (exp_over)
  );

  assign mismatch = ({alu.alu_c, alu.alu_over} != {exp_c, exp_over});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: state_d = start ? StDrive : StIdle;
      StDrive:        state_d = (ALU_LATENCY == 0) ? StCheck : StWait;
      StWait:         if (lat_q == LastLat) state_d = StCheck;
      StCheck:        state_d = (last_vec && last_op) ? StDone : StDrive;
      default:        state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StDrive) || (state_q == StWait) || (state_q == StCheck);
    done = (state_q == StDone);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q        <= '0;
      vec_q       <= '0;
      lat_q       <= '0;
      lfsr_q      <= SEED;
      drv_op_q    <= '0;
      drv_a_q     <= '0;
      drv_b_q     <= '0;
      err_count_q <= '0;
      err_op_q    <= '0;
      err_a_q     <= '0;
      err_b_q     <= '0;
      pass_q      <= 1'b0;
    end else begin
      if (accept) begin
        op_q        <= '0;
        vec_q       <= '0;
        lfsr_q      <= SEED;
        err_count_q <= '0;
        err_op_q    <= '0;
        err_a_q     <= '0;
        err_b_q     <= '0;
        pass_q      <= 1'b0;
      end
      if (state_q == StDrive) begin
        drv_op_q <= op_q;
        drv_a_q  <= vec_a;
        drv_b_q  <= vec_b;
        lat_q    <= '0;
      end
      if (state_q == StWait) lat_q <= lat_q + LatW'(1);
      if (state_q == StCheck) begin
        if (mismatch) begin
          if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
          if (err_count_q == 16'd0) begin
            err_op_q <= drv_op_q;
            err_a_q  <= drv_a_q;
            err_b_q  <= drv_b_q;
          end
        end
        if (random_vec) lfsr_q <= lfsr_step(lfsr_q);
        if (last_vec) begin
          vec_q <= '0;
          op_q  <= op_q + ALU_OP_W'(1);
        end else begin
          vec_q <= vec_q + VecW'(1);
        end
        // Result is final on the last check, so pass is valid alongside done.
        if (last_vec && last_op) pass_q <= (err_count_q == 16'd0) && !mismatch;
      end
    end
  end

  assign alu.alu_op = drv_op_q;
  assign alu.alu_a  = drv_a_q;
  assign alu.alu_b  = drv_b_q;
  assign pass       = pass_q;
  assign err_count  = err_count_q;
  assign err_op     = err_op_q;
  assign err_a      = err_a_q;
  assign err_b      = err_b_q;

endmodule
